// File: rtl/instr_loader.sv
// Boot-time MIPS program writer: packs little-endian stream bytes into 32-bit words,
// screens each opcode and writes clean words to consecutive imem addresses.
module instr_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH:0]   length_i,
    input  logic [7:0]            byte_i,
    input  logic                  byte_valid_i,
    output logic                  byte_ready_o,
    output logic                  imem_we_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    output logic [31:0]           imem_data_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [ADDR_WIDTH-1:0] err_addr_o,
    output logic                  cpu_run_o,
    output logic [2:0]            dbg_state
);

    // Byte handshake: a byte moves on a rising edge where byte_valid_i and byte_ready_o
    // are both high; byte_ready_o is high only while loading, valid may drop at any time.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state, state_next;
    logic [1:0]            byte_idx;
    logic [23:0]           partial;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic [ADDR_WIDTH-1:0] last_addr_next;
    logic                  word_ok;
    logic [31:0]           full_word;

    function automatic logic opcode_ok(input logic [5:0] op);
        case (op)
            6'h00, 6'h08, 6'h0F, 6'h0D, 6'h0C, 6'h23: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    // A full-capacity length leaves zero low bits, so subtracting one wraps to all ones.
    assign last_addr_next = (length_i > CAPACITY) ? '1
                          : length_i[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
    assign full_word      = {byte_i, partial};

    assign byte_ready_o = (state == S_LOAD);
    assign busy_o       = (state == S_LOAD) || (state == S_WRITE);
    assign done_o       = (state == S_DONE);
    assign cpu_run_o    = (state == S_DONE);
    assign error_o      = (state == S_ERROR);
    assign dbg_state    = state;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_i) state_next = (length_i == '0) ? S_DONE : S_LOAD;
            end
            S_LOAD: begin
                if (byte_valid_i && byte_idx == 2'd3) state_next = S_WRITE;
            end
            S_WRITE: begin
                if (!word_ok)               state_next = S_ERROR;
                else if (addr == last_addr) state_next = S_DONE;
                else                        state_next = S_LOAD;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            byte_idx    <= '0;
            partial     <= '0;
            addr        <= '0;
            last_addr   <= '0;
            word_ok     <= 1'b0;
            imem_we_o   <= 1'b0;
            imem_addr_o <= '0;
            imem_data_o <= '0;
            err_addr_o  <= '0;
        end else begin
            state     <= state_next;
            imem_we_o <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start_i) begin
                        addr       <= '0;
                        byte_idx   <= '0;
                        err_addr_o <= '0;
                        last_addr  <= last_addr_next;
                    end
                end
                S_LOAD: begin
                    if (byte_valid_i) begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: partial[7:0]   <= byte_i;
                            2'd1: partial[15:8]  <= byte_i;
                            2'd2: partial[23:16] <= byte_i;
                            default: begin
                                // Write port only moves for a legal word so it holds otherwise.
                                word_ok <= opcode_ok(byte_i[7:2]);
                                if (opcode_ok(byte_i[7:2])) begin
                                    imem_we_o   <= 1'b1;
                                    imem_addr_o <= addr;
                                    imem_data_o <= full_word;
                                end
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    if (!word_ok)               err_addr_o <= addr;
                    else if (addr != last_addr) addr       <= addr + ADDR_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: vector table, directed corner sequences and
// randomized programs checked against a word-level reference model.
module tb_instr_loader;

    localparam int AW = 8;
    localparam int CAP = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_i;
    logic [AW:0]   length_i;
    logic [7:0]    byte_i;
    logic          byte_valid_i;
    logic          byte_ready_o;
    logic          imem_we_o;
    logic [AW-1:0] imem_addr_o;
    logic [31:0]   imem_data_o;
    logic          busy_o;
    logic          done_o;
    logic          error_o;
    logic [AW-1:0] err_addr_o;
    logic          cpu_run_o;
    logic [2:0]    dbg_state;

    int vectors = 0;
    int miscompares = 0;

    logic [AW+31:0] exp_q[$];
    logic [31:0]    prog_q[$];
    logic [5:0]     ok_ops[6] = '{6'h00, 6'h08, 6'h0F, 6'h0D, 6'h0C, 6'h23};

    typedef struct {
        int          len;
        logic [31:0] w[3];
        logic        exp_done;
        logic        exp_error;
        logic [7:0]  exp_err_addr;
    } vec_t;

    vec_t vecs[6];

    instr_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .length_i(length_i),
        .byte_i(byte_i), .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o),
        .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_data_o(imem_data_o),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .err_addr_o(err_addr_o),
        .cpu_run_o(cpu_run_o), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every write strobe must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (imem_we_o) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                         imem_addr_o, imem_data_o);
            end else begin
                check("imem_write", {imem_addr_o, imem_data_o}, exp_q.pop_front());
            end
        end
    end

    function automatic bit is_supported(input logic [5:0] op);
        foreach (ok_ops[k]) if (ok_ops[k] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Walks the program word by word; writes stop at the first unsupported opcode.
    task automatic model_load(input int len, output int n_send, output bit e_done,
                              output bit e_err, output int e_addr);
        int eff = (len > CAP) ? CAP : len;
        n_send = eff;
        e_done = 1'b1;
        e_err  = 1'b0;
        e_addr = 0;
        for (int i = 0; i < eff; i++) begin
            logic [31:0] w = prog_q[i];
            if (!is_supported(w[31:26])) begin
                n_send = i + 1;
                e_done = 1'b0;
                e_err  = 1'b1;
                e_addr = i;
                return;
            end
            exp_q.push_back({i[AW-1:0], w});
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start_i = 1'b0;
        byte_valid_i = 1'b0;
        byte_i = '0;
        length_i = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {byte_ready_o, imem_we_o, imem_addr_o, imem_data_o, busy_o,
                                done_o, error_o, err_addr_o, cpu_run_o}, 64'd0);
        reset = 1'b0;
    endtask

    // Called just after a negedge; returns just after the negedge following the transfer.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        repeat (gap) begin
            byte_valid_i = 1'b0;
            @(negedge clk);
        end
        byte_valid_i = 1'b1;
        byte_i = b;
        while (!byte_ready_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: got ready 0 expected 1 within 50 cycles");
        end
        check("busy_during_load", busy_o, 1'b1);
        @(negedge clk);
        byte_valid_i = 1'b0;
    endtask

    task automatic run_load(input int len, input int gap_max, input int poke_at);
        int n_send, e_addr, t, nb;
        bit e_done, e_err;
        logic [31:0] w;
        model_load(len, n_send, e_done, e_err, e_addr);
        start_i = 1'b1;
        length_i = len[AW:0];
        @(negedge clk);
        start_i = 1'b0;
        if (len == 0) begin
            check("len0_done", {done_o, cpu_run_o, busy_o}, 3'b110);
        end else begin
            check("start_state", {busy_o, done_o, cpu_run_o, error_o}, 4'b1000);
            check("start_err_addr_clear", err_addr_o, 0);
        end
        nb = 0;
        for (int i = 0; i < n_send; i++) begin
            w = prog_q[i];
            for (int b = 0; b < 4; b++) begin
                if (nb == poke_at) begin
                    start_i = 1'b1;
                    length_i = '0;
                    @(negedge clk);
                    start_i = 1'b0;
                    check("start_ignored", {busy_o, done_o}, 2'b10);
                end
                send_byte(w[8*b +: 8], $urandom_range(0, gap_max));
                nb++;
            end
        end
        t = 0;
        while (!(done_o || error_o) && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            vectors++;
            miscompares++;
            $display("FAIL end_timeout: got neither done nor error after 20 cycles");
        end
        check("end_flags", {done_o, error_o, cpu_run_o, byte_ready_o, busy_o},
              {e_done, e_err, e_done, 2'b00});
        if (e_err) check("err_addr", err_addr_o, e_addr);
        check("pending_writes", exp_q.size(), 0);
    endtask

    initial begin
        vecs[0] = '{1, '{32'h20080005, 32'h0, 32'h0}, 1'b1, 1'b0, 8'd0};
        vecs[1] = '{3, '{32'h00221020, 32'h3C01ABCD, 32'h8C030004}, 1'b1, 1'b0, 8'd0};
        vecs[2] = '{2, '{32'h20080005, 32'hFC000000, 32'h0}, 1'b0, 1'b1, 8'd1};
        vecs[3] = '{1, '{32'h08000000, 32'h0, 32'h0}, 1'b0, 1'b1, 8'd0};
        vecs[4] = '{2, '{32'h34210001, 32'h30420003, 32'h0}, 1'b1, 1'b0, 8'd0};
        vecs[5] = '{3, '{32'h00000000, 32'h00000000, 32'hAC000000}, 1'b0, 1'b1, 8'd2};

        do_reset();

        // Single word with exact write and completion timing.
        prog_q = '{32'h20080005};
        exp_q.push_back({8'd0, 32'h20080005});
        start_i = 1'b1;
        length_i = 9'd1;
        @(negedge clk);
        start_i = 1'b0;
        send_byte(8'h05, 0);
        send_byte(8'h00, 0);
        send_byte(8'h08, 0);
        send_byte(8'h20, 0);
        check("t1_write_cycle", {imem_we_o, imem_addr_o, imem_data_o, done_o},
              {1'b1, 8'd0, 32'h20080005, 1'b0});
        @(negedge clk);
        check("t1_done_cycle", {imem_we_o, done_o, cpu_run_o, imem_data_o},
              {1'b0, 1'b1, 1'b1, 32'h20080005});

        foreach (vecs[i]) begin
            prog_q.delete();
            for (int j = 0; j < vecs[i].len; j++) prog_q.push_back(vecs[i].w[j]);
            run_load(vecs[i].len, 2, -1);
            check("table_flags", {done_o, error_o}, {vecs[i].exp_done, vecs[i].exp_error});
            if (vecs[i].exp_error) check("table_err_addr", err_addr_o, vecs[i].exp_err_addr);
        end
        check("hold_after_error", {imem_we_o, cpu_run_o, byte_ready_o}, 3'b000);

        // Zero-length program.
        prog_q.delete();
        run_load(0, 0, -1);

        // Reset in the middle of a word, then a fresh load.
        start_i = 1'b1;
        length_i = 9'd1;
        @(negedge clk);
        start_i = 1'b0;
        send_byte(8'hCD, 0);
        send_byte(8'hAB, 0);
        do_reset();
        prog_q = '{32'h3C01ABCD};
        run_load(1, 1, -1);

        // start_i during LOAD is ignored; start_i in DONE restarts at addr 0.
        prog_q = '{32'h20080005, 32'h3C01ABCD};
        run_load(2, 1, 3);
        prog_q = '{32'h34210001};
        run_load(1, 0, -1);

        // Oversized length saturates at capacity.
        prog_q.delete();
        for (int i = 0; i < CAP; i++) prog_q.push_back({6'h08, 26'($urandom)});
        run_load(300, 0, -1);
        check("sat_last_addr", imem_addr_o, CAP - 1);

        // Randomized programs with random stream gaps.
        for (int r = 0; r < 12; r++) begin
            int len = $urandom_range(1, 5);
            prog_q.delete();
            for (int i = 0; i < len; i++) begin
                logic [5:0] op;
                if ($urandom_range(0, 9) < 8) op = ok_ops[$urandom_range(0, 5)];
                else op = 6'($urandom);
                prog_q.push_back({op, 26'($urandom)});
            end
            run_load(len, 3, -1);
        end

        check("final_pending_writes", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
